// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture and dump units.
// Holds the RAM geometry defaults, the dump FSM encoding and the circular address step.
package la_pkg;

    localparam int ENTRIES_DEF = 384;
    localparam int LOG2_DEF    = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LATCH = 3'd2,
        ST_TXW   = 3'd3,
        ST_FIN   = 3'd4
    } dump_state_t;

    // Next address in a ring of 'entries' locations; callers truncate to their width.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input logic [31:0] entries);
        return (addr == entries - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/dump_unit.sv
// Streams a completed capture out of the circular sample RAM, oldest sample first,
// one byte per UART transmit handshake (trmt strobe out, tx_done back).
module dump_unit
    import la_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int LOG2    = LOG2_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump,
    input  logic [LOG2-1:0] start_addr,
    output logic [LOG2-1:0] raddr,
    input  logic [7:0]      rdata,
    output logic [7:0]      tx_data,
    output logic            trmt,
    input  logic            tx_done,
    output logic            busy,
    output logic            dump_done
);

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    dump_state_t     r_state;
    dump_state_t     w_state_next;
    logic [LOG2-1:0] r_raddr;
    logic [LOG2-1:0] r_cnt;
    logic [7:0]      r_tx_data;
    logic            r_trmt;
    logic            r_dump_done;
    logic [LOG2-1:0] w_raddr_inc;
    logic [LOG2-1:0] w_start_eff;

    assign w_raddr_inc = LOG2'(wrap_inc(32'(r_raddr), 32'(ENTRIES)));
    // A start address past the ring can only come from a stale capture; begin at 0.
    assign w_start_eff = (32'(start_addr) >= 32'(ENTRIES)) ? '0 : start_addr;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (dump) w_state_next = ST_RD;
            ST_RD:    w_state_next = ST_LATCH;
            ST_LATCH: w_state_next = ST_TXW;
            ST_TXW:   if (tx_done) w_state_next = (r_cnt == LAST) ? ST_FIN : ST_RD;
            ST_FIN:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raddr     <= '0;
            r_cnt       <= '0;
            r_tx_data   <= 8'h00;
            r_trmt      <= 1'b0;
            r_dump_done <= 1'b0;
        end else begin
            r_trmt      <= 1'b0;
            r_dump_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (dump) begin
                        r_raddr <= w_start_eff;
                        r_cnt   <= '0;
                    end
                end
                ST_LATCH: begin
                    r_tx_data <= rdata;
                    r_trmt    <= 1'b1;
                end
                ST_TXW: begin
                    if (tx_done && (r_cnt != LAST)) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_raddr <= w_raddr_inc;
                    end
                end
                ST_FIN:  r_dump_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign raddr     = r_raddr;
    assign tx_data   = r_tx_data;
    assign trmt      = r_trmt;
    assign busy      = (r_state != ST_IDLE);
    assign dump_done = r_dump_done;

endmodule
